// File: rtl/trng_sample_ctrl.sv
// TRNG sampling sequencer: warms up the ring source, strobes the balance filter at a
// programmable rate, counts filtered bits into one EHR block and retries on vn_err.
module trng_sample_ctrl #(
    parameter int unsigned EHR_BITS   = 192,
    parameter int unsigned WARMUP_CYC = 16,
    parameter int unsigned MAX_RETRY  = 3,
    parameter int unsigned SCW        = 16
) (
    input  logic           rng_clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           stop,
    input  logic           err_clr,
    input  logic [SCW-1:0] sample_cnt,
    input  logic           vn_err,
    input  logic           balance_filter_valid,
    output logic           rnd_src_en,
    output logic           cntr_balance_valid,
    output logic           rst_trng_logic,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [1:0]     retry_cnt,
    output logic [7:0]     bit_cnt
);

    localparam int unsigned WCW = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
    localparam int unsigned BCW = 8;
    localparam int unsigned RCW = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WARMUP = 3'd1,
        SAMPLE = 3'd2,
        FLUSH  = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_e;

    state_e         state_q, state_d;
    logic [SCW-1:0] rate_q, rate_d;
    logic [SCW-1:0] rate_cnt_q, rate_cnt_d;
    logic [WCW-1:0] warm_q, warm_d;
    logic [RCW-1:0] retry_q, retry_d;
    logic [BCW-1:0] bits_q, bits_d;
    logic           stop_flush;

    logic rnd_src_en_q, rnd_src_en_d;
    logic strobe_q, strobe_d;
    logic rst_logic_q, rst_logic_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic err_q, err_d;

    // Next-state, counters and registered output decode
    always_comb begin
        state_d    = state_q;
        rate_d     = rate_q;
        rate_cnt_d = rate_cnt_q;
        warm_d     = warm_q;
        retry_d    = retry_q;
        bits_d     = bits_q;
        stop_flush = 1'b0;

        if (stop) begin
            state_d    = IDLE;
            stop_flush = (state_q == WARMUP) || (state_q == SAMPLE) ||
                         (state_q == FLUSH)  || (state_q == DONE);
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = WARMUP;
                        rate_d  = (sample_cnt == '0) ? SCW'(1) : sample_cnt;
                        retry_d = '0;
                        bits_d  = '0;
                        warm_d  = WCW'(WARMUP_CYC - 1);
                    end
                end
                WARMUP: begin
                    rate_cnt_d = rate_q;
                    if (warm_q == '0) begin
                        state_d = SAMPLE;
                    end else begin
                        warm_d = warm_q - WCW'(1);
                    end
                end
                SAMPLE: begin
                    // Strobe fires when the counter shows 1, reloading in the same cycle
                    rate_cnt_d = (rate_cnt_q == SCW'(1)) ? rate_q : rate_cnt_q - SCW'(1);
                    if (vn_err) begin
                        state_d = FLUSH;
                        bits_d  = '0;
                        retry_d = retry_q + RCW'(1);
                    end else if (balance_filter_valid) begin
                        bits_d = bits_q + BCW'(1);
                        if (bits_q == BCW'(EHR_BITS - 1)) begin
                            state_d = DONE;
                        end
                    end
                end
                FLUSH: begin
                    warm_d  = WCW'(WARMUP_CYC - 1);
                    state_d = (retry_q == RCW'(MAX_RETRY)) ? ERR : WARMUP;
                end
                DONE: begin
                    state_d = IDLE;
                end
                ERR: begin
                    if (err_clr) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        rnd_src_en_d = (state_d == WARMUP) || (state_d == SAMPLE);
        strobe_d     = (state_d == SAMPLE) && (rate_cnt_d == SCW'(1));
        rst_logic_d  = (state_d == FLUSH) || stop_flush;
        busy_d       = (state_d != IDLE) && (state_d != ERR);
        done_d       = (state_d == DONE);
        err_d        = (state_d == ERR);
    end

    always_ff @(posedge rng_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rate_q       <= '0;
            rate_cnt_q   <= '0;
            warm_q       <= '0;
            retry_q      <= '0;
            bits_q       <= '0;
            rnd_src_en_q <= 1'b0;
            strobe_q     <= 1'b0;
            rst_logic_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rate_q       <= rate_d;
            rate_cnt_q   <= rate_cnt_d;
            warm_q       <= warm_d;
            retry_q      <= retry_d;
            bits_q       <= bits_d;
            rnd_src_en_q <= rnd_src_en_d;
            strobe_q     <= strobe_d;
            rst_logic_q  <= rst_logic_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign rnd_src_en         = rnd_src_en_q;
    assign cntr_balance_valid = strobe_q;
    assign rst_trng_logic     = rst_logic_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign err                = err_q;
    assign retry_cnt          = retry_q;
    assign bit_cnt            = bits_q;

endmodule
